// File: rtl/mult_div_unit.sv
// Multi-cycle integer multiply/divide unit with HI/LO result registers.
// Signed and unsigned shift-add multiply and restoring divide, 33 cycles from start to result.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [0:31] rsData,
    input  logic [0:31] rtData,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [0:31] wrData,
    output logic        busy,
    output logic        done,
    output logic [0:31] hi,
    output logic [0:31] lo,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_opa;
    logic [63:0] r_acc;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic [31:0] w_rs;
    logic [31:0] w_rt;
    logic [31:0] w_wr;
    logic        w_signed;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_trial;
    logic [63:0] w_div_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_rs     = rsData;
    assign w_rt     = rtData;
    assign w_wr     = wrData;
    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & w_rs[31];
    assign w_rt_neg = w_signed & w_rt[31];
    assign w_rs_mag = w_rs_neg ? (~w_rs + 32'd1) : w_rs;
    assign w_rt_mag = w_rt_neg ? (~w_rt + 32'd1) : w_rt;

    // Multiply: r_acc = {partial, multiplier}; low bit of multiplier selects the add, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opa} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: r_acc = {remainder, dividend/quotient}; borrow in bit 32 means restore.
    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_trial = w_div_shift - {1'b0, r_opa};
    assign w_div_next  = w_div_trial[32] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                         : {w_div_trial[31:0], r_acc[30:0], 1'b1};

    // A zero divisor leaves the raw dividend in the remainder, so only the quotient needs forcing.
    assign w_prod_fix = (r_op == OP_MULT && (r_sign_a ^ r_sign_b)) ? (~r_acc + 64'd1) : r_acc;
    assign w_rem_fix  = (r_op == OP_DIV && r_sign_a) ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    always_comb begin
        w_quo_fix = r_acc[31:0];
        if (r_opa == 32'd0) begin
            w_quo_fix = 32'hFFFF_FFFF;
        end else if (r_op == OP_DIV && (r_sign_a ^ r_sign_b)) begin
            w_quo_fix = ~r_acc[31:0] + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_RUN;
            S_RUN:    if (r_cnt == 6'd31) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= 2'b00;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_opa    <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 6'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_sign_a <= w_rs_neg;
                        r_sign_b <= w_rt_neg;
                        r_cnt    <= 6'd0;
                        if (op[1]) begin
                            r_opa <= w_rt_mag;
                            r_acc <= {32'd0, w_rs_mag};
                        end else begin
                            r_opa <= w_rs_mag;
                            r_acc <= {32'd0, w_rt_mag};
                        end
                    end else begin
                        if (mthi) r_hi <= w_wr;
                        if (mtlo) r_lo <= w_wr;
                    end
                end
                S_RUN: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FINISH: begin
                    if (r_op[1]) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table through a shared op runner,
// plus hand-written sequences for mthi/mtlo, start priority and reset abort.
module tb_mult_div_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] rsData  = 32'd0;
    logic [31:0] rtData  = 32'd0;
    logic        mthi    = 1'b0;
    logic        mtlo    = 1'b0;
    logic [31:0] wrData  = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    mult_div_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .rsData      (rsData),
        .rtData      (rtData),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wrData      (wrData),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .o_dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts one op, then drives junk (start, mthi/mtlo, new operands) every busy cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_ok);
        @(negedge clock);
        op = o; rsData = a; rtData = b; start = 1'b1; mthi = 1'b0; mtlo = 1'b0;
        @(posedge clock);
        #1;
        busy_ok = busy;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            start  = 1'b1;
            op     = 2'($urandom_range(0, 3));
            rsData = $urandom;
            rtData = $urandom;
            mthi   = 1'b1;
            mtlo   = 1'b1;
            wrData = $urandom;
            @(posedge clock);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    endtask

    initial begin
        int lat;
        logic ok;
        logic [63:0] exp;

        vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[8]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[10] = '{MULT,  32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        vecs[11] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

        // Reset values while reset is held.
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, ok);
            exp = exp_q.pop_front();
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_busy", i), {63'd0, ok}, 64'd1);
            check($sformatf("vec%0d_hilo", i), {hi, lo}, exp);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_done_pulse", i), {62'd0, done, busy}, 64'd0);
        end

        // mthi/mtlo in IDLE write both registers without a done pulse.
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; wrData = 32'h0000_1234;
        @(posedge clock);
        #1;
        check("mt_both_hilo", {hi, lo}, {32'h0000_1234, 32'h0000_1234});
        check("mt_both_done", {62'd0, done, busy}, 64'd0);
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b1; wrData = 32'h0000_BEEF;
        @(posedge clock);
        #1;
        check("mtlo_only", {hi, lo}, {32'h0000_1234, 32'h0000_BEEF});

        // start wins over simultaneous mthi/mtlo.
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; wrData = 32'h0000_5678;
        start = 1'b1; op = MULTU; rsData = 32'd2; rtData = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("start_wins_busy", {63'd0, busy}, 64'd1);
        check("start_wins_hilo", {hi, lo}, {32'h0000_1234, 32'h0000_BEEF});
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        check("start_wins_latency", 64'(lat), 64'd33);
        check("start_wins_result", {hi, lo}, {32'd0, 32'd6});

        // Reset mid-operation: abort, clear, and no later done.
        @(negedge clock);
        start = 1'b1; op = MULTU; rsData = 32'd2; rtData = 32'd3;
        @(posedge clock);
        #1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            start = (c == 5);
            op    = DIVU;
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done || busy || hi != 32'd0 || lo != 32'd0) ok = 1'b0;
        end
        check("abort_quiet", {63'd0, ok}, 64'd1);

        // First start accepted on the first edge after reset release.
        #1 reset_n = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
        run_op(DIVU, 32'd100, 32'd7, lat, ok);
        check("post_reset_latency", 64'(lat), 64'd33);
        check("post_reset_result", {hi, lo}, {32'd2, 32'd14});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
